// File: rtl/div_pkg.sv
// Shared types for the sequential divider: operation codes, FSM states and
// small decode helpers used by the top level.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_signed(input op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem(input op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_divider_lzc.sv
// Leading-zero counter: number of zero bits above the highest set bit,
// WIDTH when the input is all zero.
module lzc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]           i_data,
    output logic [$clog2(WIDTH+1)-1:0] o_count,
    output logic                       o_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        o_count = CW'(WIDTH);
        // Scanning upwards lets the highest set bit have the final say.
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign o_zero = (i_data == '0);

endmodule

// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider with early-out on leading zeros and a
// single-entry result cache shared between the quotient and remainder ops.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1,
    parameter int CACHE_EN  = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           r_state, w_state_next;
    op_e              r_op;
    logic             r_signed;
    logic [WIDTH-1:0] r_dividend, r_divisor;
    logic [WIDTH-1:0] r_dvs_abs;
    logic             r_neg_q, r_neg_r;
    logic [WIDTH-1:0] r_quo, r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res_q, r_res_r;

    logic             r_c_valid, r_c_signed;
    logic [WIDTH-1:0] r_c_dividend, r_c_divisor;

    op_e              w_op_in;
    logic             w_hit;
    logic             w_dvd_neg, w_dvs_neg, w_dvd_zero;
    logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_dvd_aligned;
    logic [CW-1:0]    w_lz, w_k, w_shift;
    logic             w_div0, w_ovf, w_special;
    logic [WIDTH-1:0] w_spec_q, w_spec_r;
    logic [WIDTH:0]   w_rem_shift, w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_step, w_quo_step;
    logic [WIDTH-1:0] w_fix_q, w_fix_r;

    assign w_op_in = op_e'(op_i);

    // The result registers always hold the last completed pair, so a hit
    // only needs to match the key; the data is already in place.
    assign w_hit = (CACHE_EN != 0) && r_c_valid
                && (dividend_i == r_c_dividend) && (divisor_i == r_c_divisor)
                && (is_signed(w_op_in) == r_c_signed);

    // Operand preparation
    assign w_dvd_neg = r_signed && r_dividend[WIDTH-1];
    assign w_dvs_neg = r_signed && r_divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -r_dividend : r_dividend;
    assign w_dvs_abs = w_dvs_neg ? -r_divisor : r_divisor;

    lzc #(.WIDTH(WIDTH)) u_lzc (
        .i_data  (w_dvd_abs),
        .o_count (w_lz),
        .o_zero  (w_dvd_zero)
    );

    assign w_k           = (EARLY_OUT != 0) ? (CW'(WIDTH) - w_lz) : CW'(WIDTH);
    assign w_shift       = (EARLY_OUT != 0) ? w_lz : '0;
    assign w_dvd_aligned = w_dvd_abs << w_shift;

    assign w_div0    = (r_divisor == '0);
    assign w_ovf     = r_signed && (r_dividend == MOST_NEG) && (r_divisor == '1);
    assign w_special = w_div0 || w_ovf || w_dvd_zero;
    assign w_spec_q  = w_div0 ? '1 : (w_ovf ? MOST_NEG : '0);
    assign w_spec_r  = w_div0 ? r_dividend : '0;

    // One restoring step; the partial remainder is always below the divisor,
    // so one extra bit is enough for the trial subtraction's sign.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_dvs_abs};
    assign w_ge        = !w_diff[WIDTH];
    assign w_rem_step  = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_step  = {r_quo[WIDTH-2:0], w_ge};

    assign w_fix_q = r_neg_q ? -r_quo : r_quo;
    assign w_fix_r = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = ST_IDLE;
        end else if (!stall_i) begin
            case (r_state)
                ST_IDLE: if (valid_i) w_state_next = w_hit ? ST_DONE : ST_PREP;
                ST_PREP: w_state_next = w_special ? ST_DONE : ST_DIV;
                ST_DIV:  if (r_cnt == CW'(1)) w_state_next = ST_FIX;
                ST_FIX:  w_state_next = ST_DONE;
                ST_DONE: if (ready_i) w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_op         <= OP_DIV;
            r_signed     <= 1'b0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_dvs_abs    <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_res_q      <= '0;
            r_res_r      <= '0;
            r_c_valid    <= 1'b0;
            r_c_signed   <= 1'b0;
            r_c_dividend <= '0;
            r_c_divisor  <= '0;
        end else if (flush_i) begin
            r_c_valid <= 1'b0;
        end else if (!stall_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_op       <= w_op_in;
                        r_signed   <= is_signed(w_op_in);
                        r_dividend <= dividend_i;
                        r_divisor  <= divisor_i;
                    end
                end
                ST_PREP: begin
                    r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                    r_neg_r   <= w_dvd_neg;
                    r_dvs_abs <= w_dvs_abs;
                    r_quo     <= w_dvd_aligned;
                    r_rem     <= '0;
                    r_cnt     <= w_k;
                    if (w_special) begin
                        r_res_q      <= w_spec_q;
                        r_res_r      <= w_spec_r;
                        r_c_valid    <= (CACHE_EN != 0);
                        r_c_signed   <= r_signed;
                        r_c_dividend <= r_dividend;
                        r_c_divisor  <= r_divisor;
                    end
                end
                ST_DIV: begin
                    r_quo <= w_quo_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    r_res_q      <= w_fix_q;
                    r_res_r      <= w_fix_r;
                    r_c_valid    <= (CACHE_EN != 0);
                    r_c_signed   <= r_signed;
                    r_c_dividend <= r_dividend;
                    r_c_divisor  <= r_divisor;
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (r_state == ST_IDLE);
    assign busy_o   = (r_state != ST_IDLE);
    assign valid_o  = (r_state == ST_DONE);
    assign result_o = valid_o ? (is_rem(r_op) ? r_res_r : r_res_q) : '0;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal values are even numbers 8..64.
REQ-002 Parameter EARLY_OUT, default 1: when 1, skip leading-zero dividend bits; when 0, always iterate WIDTH times.
REQ-003 Parameter CACHE_EN, default 1: when 1, enable the last-result cache for DIV/REM pairs.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 reset_i  in  1  reset; asynchronous, active-high.
REQ-006 flush_i  in  1  kills the operation in flight.
REQ-007 stall_i  in  1  freezes all internal state.
REQ-008 valid_i  in  1  request valid.
REQ-009 ready_o  out  1  request can be accepted.
REQ-010 op_i  in  2  operation select: DIV, DIVU, REM or REMU.
REQ-011 dividend_i  in  WIDTH  dividend operand.
REQ-012 divisor_i  in  WIDTH  divisor operand.
REQ-013 valid_o  out  1  result valid.
REQ-014 ready_i  in  1  consumer takes the result.
REQ-015 result_o  out  WIDTH  quotient for DIV/DIVU, remainder for REM/REMU.
REQ-016 busy_o  out  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, PREP, DIV, FIX, DONE.
REQ-018 Accept occurs when valid_i && ready_o && !stall_i; ready_o = (state==IDLE).
- Accept registers op, operands and signedness.
- Next state is PREP, or DONE on a cache hit.
REQ-019 PREP (1 cycle):
- forms |dividend| and |divisor|; signed only for DIV/REM;
- computes k = number of significant bits of |dividend|; k = WIDTH when EARLY_OUT=0.
REQ-020 PREP special cases go straight to DONE:
- divisor 0: quotient all-ones, remainder = raw dividend;
- signed, dividend = most-negative, divisor = -1: quotient = most-negative, remainder 0;
- dividend 0: quotient 0, remainder 0.
REQ-021 DIV: one restoring radix-2 step per cycle over k cycles, MSB first, using WIDTH+1-bit compare/subtract; then FIX.
REQ-022 FIX (1 cycle) applies the sign corrections:
- quotient is negated when the operand signs differ (signed ops only);
- remainder takes the dividend's sign.
REQ-023 Latency from accept cycle T:
- valid_o first high in cycle T+3+k for the normal path;
- T+2 for special cases;
- T+1 for a cache hit.
REQ-024 DONE holds valid_o and a stable result_o until ready_i; it returns to IDLE on the edge where valid_o && ready_i && !stall_i.
REQ-025 No new request is accepted in the same cycle a result is consumed; the next accept is possible in the following cycle.
REQ-026 Cache (CACHE_EN=1):
- on each FIX/special completion, store dividend, divisor, signedness, quotient and remainder;
- hit = valid entry with equal operands and equal signedness (DIV/REM share an entry; DIVU/REMU share an entry);
- on a hit, result_o selects quotient or remainder per the new op.
REQ-027 stall_i high: FSM, counters, datapath and cache hold; no accept; no result consumed; outputs hold their values.
REQ-028 flush_i (priority over stall_i and over all other inputs):
- next state IDLE;
- valid_o low in the following cycle;
- cache invalidated;
- any simultaneous accept is discarded.
REQ-029 result_o is 0 whenever valid_o is low.

Reset
REQ-030 reset_i asserted (any time, including mid-operation): state IDLE, cache invalid, all datapath registers 0.
REQ-031 Output values during reset: ready_o 1, valid_o 0, busy_o 0, result_o 0.
REQ-032 The first accept is possible in the first cycle after reset_i deasserts.

Structure
REQ-033 Package div_pkg holds the op enum (DIV=0, DIVU=1, REM=2, REMU=3), the state enum and a helper is_signed(op).
REQ-034 Sub-module lzc (parametrised WIDTH leading-zero counter with an all-zero flag) computes k; it is instantiated once.
REQ-035 All other logic is contained in seq_divider; no multipliers are used.

Verification
REQ-036 DIVU 100/7, WIDTH=32, EARLY_OUT=1 -> result 14 in cycle T+10 (k=7); a following REMU 100/7 hits the cache -> result 2 at T+1.
REQ-037 DIV -7/2 -> result -3; REM -7/2 -> -1; DIV 7/-2 -> -3; REM 7/-2 -> 1.
REQ-038 Special cases:
- DIV 5/0 -> 0xFFFFFFFF at T+2;
- REMU 5/0 -> 5;
- DIV 0x80000000/-1 -> 0x80000000;
- REM of the same operands -> 0.
REQ-039 Stall and flush:
- stall_i high for 5 cycles mid-DIV -> result value unchanged and latency extended by exactly 5;
- flush_i mid-DIV -> IDLE next cycle, no valid_o, next op is a cache miss.
REQ-040 Backpressure: ready_i low for 4 cycles in DONE -> valid_o and result_o stable; a request asserted in the consume cycle is accepted one cycle later.
REQ-041 Random signed/unsigned ops at WIDTH=8 and WIDTH=64, EARLY_OUT=0/1 and CACHE_EN=0/1 -> match the reference model; reset_i asserted mid-DIV -> outputs at reset values immediately.
